// File: rtl/transpose_pkg.sv
// Shared types and sizing for the streaming-transpose sequencer.
// Imported by the scheduler; no logic lives here.
package transpose_pkg;

    localparam int MATRIX_DIM = 32;
    localparam int ROW_W      = $clog2(MATRIX_DIM);
    localparam int TILE_W     = 16;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        STREAM,
        DRAIN,
        FIN
    } sched_state_t;

endpackage

// File: rtl/transpose_stream_sched.sv
// Job-based sequencer for the 32x32 streaming transpose core.
// Stage 0 decides the advance; stage 1 drives core enable and output writes.
module transpose_stream_sched #(
    parameter int MATRIX_DIM = 32,
    parameter int TILE_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    input  logic [TILE_W-1:0] cfg_num_tiles,
    output logic              cfg_ready,
    input  logic              abort,
    input  logic              in_fifo_empty,
    output logic              in_fifo_re,
    input  logic              out_fifo_almostfull,
    output logic              core_clk_en,
    output logic              core_start,
    output logic              out_fifo_we,
    output logic              busy,
    output logic              done,
    output logic [TILE_W-1:0] tiles_done
);

    import transpose_pkg::*;

    localparam int RW = $clog2(MATRIX_DIM);
    localparam logic [RW-1:0] ROW_LAST = RW'(MATRIX_DIM - 1);

    sched_state_t      state;
    sched_state_t      state_nx;
    logic [RW-1:0]     row_cnt;
    logic [TILE_W-1:0] tile_cnt;
    logic [TILE_W-1:0] num_q;
    logic [TILE_W-1:0] tiles_done_q;

    logic adv;
    logic wrap;
    logic hs;
    logic kill;
    logic last_tile;
    logic emit;
    logic adv_q;
    logic emit_q;

    assign hs        = cfg_valid & (state == IDLE);
    assign kill      = abort & (state != IDLE);
    assign wrap      = adv & (row_cnt == ROW_LAST);
    assign last_tile = (tile_cnt + TILE_W'(1)) == num_q;
    assign emit      = (state == STREAM) | (state == DRAIN);

    always_comb begin
        adv = 1'b0;
        unique case (state)
            FILL:    adv = !in_fifo_empty;
            STREAM:  adv = !in_fifo_empty & !out_fifo_almostfull;
            DRAIN:   adv = !out_fifo_almostfull;
            default: adv = 1'b0;
        endcase
        if (abort)
            adv = 1'b0;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (hs)
                    state_nx = (cfg_num_tiles != '0) ? FILL : FIN;
            end
            FILL: begin
                if (wrap)
                    state_nx = (num_q > TILE_W'(1)) ? STREAM : DRAIN;
            end
            STREAM: begin
                if (wrap && last_tile)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                if (wrap)
                    state_nx = FIN;
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (kill)
            state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            row_cnt      <= '0;
            tile_cnt     <= '0;
            num_q        <= '0;
            tiles_done_q <= '0;
        end else begin
            state <= state_nx;
            if (kill) begin
                row_cnt      <= '0;
                tile_cnt     <= '0;
                tiles_done_q <= '0;
            end else begin
                if (hs) begin
                    num_q        <= cfg_num_tiles;
                    row_cnt      <= '0;
                    tile_cnt     <= '0;
                    tiles_done_q <= '0;
                end
                if (adv)
                    row_cnt <= wrap ? '0 : row_cnt + RW'(1);
                // tile_cnt tracks tiles read in, tiles_done tracks tiles written out
                if (wrap && (state == FILL || state == STREAM))
                    tile_cnt <= tile_cnt + TILE_W'(1);
                if (wrap && emit)
                    tiles_done_q <= tiles_done_q + TILE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            adv_q  <= 1'b0;
            emit_q <= 1'b0;
        end else begin
            adv_q  <= adv;
            emit_q <= emit;
        end
    end

    assign in_fifo_re  = adv & ((state == FILL) | (state == STREAM));
    assign core_clk_en = adv_q;
    assign core_start  = adv_q;
    assign out_fifo_we = adv_q & emit_q;
    assign cfg_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign done        = (state == FIN);
    assign tiles_done  = tiles_done_q;

endmodule
